// File: rtl/fp16_square_pipe.sv
// Two-stage elastic FP16 squarer (result = x*x), RNE rounding, subnormals flushed to zero.
// Stage 1 classifies and forms the 11x11 significand product; stage 2 normalises, rounds and packs.
module fp16_square_pipe #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [15:0]          operand_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [15:0]          result_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_NAN  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_ZERO = 2'd3
    } cls_e;

    // Returns {overflow, underflow, result} for a normal operand given P and its biased exponent.
    function automatic logic [17:0] round_pack(input logic [21:0] p, input logic [4:0] e);
        logic [9:0]         mant;
        logic               guard;
        logic               sticky;
        logic               inc;
        logic [10:0]        msum;
        logic signed [6:0]  ex;
        logic [17:0]        packed_res;
        if (p[21]) begin
            mant   = p[20:11];
            guard  = p[10];
            sticky = |p[9:0];
            ex     = $signed({1'b0, e, 1'b0}) - 7'sd14;
        end else begin
            mant   = p[19:10];
            guard  = p[9];
            sticky = |p[8:0];
            ex     = $signed({1'b0, e, 1'b0}) - 7'sd15;
        end
        inc  = guard & (sticky | mant[0]);
        msum = {1'b0, mant} + {10'd0, inc};
        // Carry out of the mantissa leaves msum[9:0] at zero, which is the required mantissa.
        if (msum[10]) begin
            ex = ex + 7'sd1;
        end
        mant = msum[9:0];
        if (ex >= 7'sd31) begin
            packed_res = {2'b10, 16'h7C00};
        end else if (ex <= 7'sd0) begin
            packed_res = {2'b01, 16'h0000};
        end else begin
            packed_res = {2'b00, 1'b0, ex[4:0], mant};
        end
        return packed_res;
    endfunction

    logic                 adv1;
    logic                 adv2;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s2_vld_q, s2_vld_d;

    cls_e                 cls_p1_d, cls_p1_q;
    logic                 sub_p1_d, sub_p1_q;
    logic [21:0]          prod_p1_d, prod_p1_q;
    logic [4:0]           exp_p1_q;
    logic [TAG_WIDTH-1:0] tag_p1_q;
    logic [21:0]          sig_ext;

    logic [15:0]          res_p2_d, res_p2_q;
    logic                 ovf_p2_d, ovf_p2_q;
    logic                 unf_p2_d, unf_p2_q;
    logic [TAG_WIDTH-1:0] tag_p2_q;
    logic [17:0]          norm_pack;

    assign adv2       = !s2_vld_q | out_ready_i;
    assign adv1       = !s1_vld_q | adv2;
    assign in_ready_o = adv1;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (flush_i) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (adv1) s1_vld_d = in_valid_i;
            if (adv2) s2_vld_d = s1_vld_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    // ---- stage 1: classify operand, form significand product ----
    assign sig_ext = {11'd0, 1'b1, operand_i[9:0]};

    always_comb begin
        cls_p1_d  = CLS_NORM;
        sub_p1_d  = |operand_i[9:0];
        prod_p1_d = sig_ext * sig_ext;
        if (operand_i[14:10] == 5'd31) begin
            cls_p1_d = (operand_i[9:0] != 10'd0) ? CLS_NAN : CLS_INF;
        end else if (operand_i[14:10] == 5'd0) begin
            cls_p1_d = CLS_ZERO;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && adv1) begin
            cls_p1_q  <= cls_p1_d;
            sub_p1_q  <= sub_p1_d;
            prod_p1_q <= prod_p1_d;
            exp_p1_q  <= operand_i[14:10];
            tag_p1_q  <= tag_i;
        end
    end

    // ---- stage 2: normalise, round, range-check, pack ----
    assign norm_pack = round_pack(prod_p1_q, exp_p1_q);

    always_comb begin
        res_p2_d = 16'h0000;
        ovf_p2_d = 1'b0;
        unf_p2_d = 1'b0;
        case (cls_p1_q)
            CLS_NAN:  res_p2_d = 16'h7E00;
            CLS_INF:  res_p2_d = 16'h7C00;
            CLS_ZERO: unf_p2_d = sub_p1_q;
            default: begin
                res_p2_d = norm_pack[15:0];
                ovf_p2_d = norm_pack[17];
                unf_p2_d = norm_pack[16];
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_p2_q <= 16'h0000;
            ovf_p2_q <= 1'b0;
            unf_p2_q <= 1'b0;
            tag_p2_q <= '0;
        end else if (adv2 && s1_vld_q) begin
            res_p2_q <= res_p2_d;
            ovf_p2_q <= ovf_p2_d;
            unf_p2_q <= unf_p2_d;
            tag_p2_q <= tag_p1_q;
        end
    end

    assign out_valid_o = s2_vld_q;
    assign result_o    = res_p2_q;
    assign tag_o       = tag_p2_q;
    assign overflow_o  = ovf_p2_q;
    assign underflow_o = unf_p2_q;

endmodule

// File: tb/tb_fp16_square_pipe.sv
// Directed bench for fp16_square_pipe: squares, rounding, specials, backpressure, flush, reset,
// plus a sweep of every FP16 encoding against a real-valued RNE/FTZ reference.
module tb_fp16_square_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [3:0]  tag_out;
    logic        ovf;
    logic        unf;

    int checks = 0;
    int errors = 0;

    fp16_square_pipe #(.TAG_WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .operand_i   (operand),
        .tag_i       (tag_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Real-valued reference: {overflow, underflow, result}.
    function automatic logic [17:0] ref_sq(input logic [15:0] x);
        int  e;
        int  m;
        int  ex;
        int  mi;
        int  be;
        real r;
        real frac;
        real rem;
        e = int'(x[14:10]);
        m = int'(x[9:0]);
        if (e == 31) return (m != 0) ? {2'b00, 16'h7E00} : {2'b00, 16'h7C00};
        if (e == 0) return {1'b0, (m != 0), 16'h0000};
        r  = 1.0 + m / 1024.0;
        r  = r * r;
        ex = 2 * (e - 15);
        while (r >= 2.0) begin
            r  = r / 2.0;
            ex = ex + 1;
        end
        frac = (r - 1.0) * 1024.0;
        mi   = int'($floor(frac));
        rem  = frac - mi;
        if (rem > 0.5 || (rem == 0.5 && mi[0])) mi = mi + 1;
        if (mi == 1024) begin
            mi = 0;
            ex = ex + 1;
        end
        be = ex + 15;
        if (be >= 31) return {2'b10, 16'h7C00};
        if (be <= 0) return {2'b01, 16'h0000};
        return {2'b00, 1'b0, be[4:0], mi[9:0]};
    endfunction

    task automatic idle();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        operand   = 16'h0000;
        tag_in    = 4'h0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, result, tag_out, ovf, unf} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b r=%h t=%h o=%0b u=%0b, want all 0",
                     out_valid, result, tag_out, ovf, unf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    // Back-to-back stream; result i appears one edge after the edge that accepts i.
    task automatic run_stream(input string name, input logic [15:0] ops[], input logic [17:0] exps[]);
        int n;
        n = ops.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                in_valid = 1'b1;
                operand  = ops[i];
                tag_in   = 4'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            checks++;
            if (i == 0) begin
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_latency: out_valid=%0b after accept edge, want 0", name, out_valid);
                end
            end else if ({out_valid, tag_out, ovf, unf, result} !== {1'b1, 4'(i), exps[i-1]}) begin
                errors++;
                $display("FAIL %s[%0d] op=%h: got v=%0b t=%h o=%0b u=%0b r=%h, want v=1 t=%h o=%0b u=%0b r=%h",
                         name, i - 1, ops[i-1], out_valid, tag_out, ovf, unf, result,
                         4'(i), exps[i-1][17], exps[i-1][16], exps[i-1][15:0]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain: out_valid=%0b want 0", name, out_valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] ops[]  = '{16'h3C00, 16'h4000, 16'h3E00, 16'h4200, 16'hBE00};
        logic [17:0] exps[] = '{18'h03C00, 18'h04400, 18'h04080, 18'h04880, 18'h04080};
        run_stream("basic", ops, exps);
    endtask

    task automatic test_rounding();
        logic [15:0] ops[]  = '{16'h3C01, 16'h3FFF};
        logic [17:0] exps[] = '{18'h03C02, 18'h043FE};
        run_stream("round", ops, exps);
    endtask

    task automatic test_specials();
        logic [15:0] ops[]  = '{16'h7E01, 16'hFC00, 16'h5C00, 16'h7BFF,
                                16'h1C00, 16'h0001, 16'h8000, 16'h2000};
        logic [17:0] exps[] = '{18'h07E00, 18'h07C00, 18'h27C00, 18'h27C00,
                                18'h10000, 18'h10000, 18'h00000, 18'h00400};
        run_stream("special", ops, exps);
    endtask

    task automatic test_backpressure();
        logic [15:0] ops[2]  = '{16'h4000, 16'h4200};
        logic [15:0] exps[2] = '{16'h4400, 16'h4880};
        logic [3:0]  tags[2] = '{4'hA, 4'hB};
        int          acc;
        int          drained;
        logic [15:0] held;
        acc       = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            operand  = (acc < 2) ? ops[acc] : 16'h3C00;
            tag_in   = (acc < 2) ? tags[acc] : 4'hF;
            #1;
            if (in_ready) acc++;
            @(posedge clk);
            #1;
            if (c == 1) held = result;
            if (c >= 2) begin
                checks++;
                if (result !== held || out_valid !== 1'b1 || tag_out !== 4'hA) begin
                    errors++;
                    $display("FAIL bp_stable[%0d]: got v=%0b r=%h t=%h, want v=1 r=%h t=a",
                             c, out_valid, result, tag_out, held);
                end
            end
        end
        checks++;
        if (acc !== 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: accepted=%0d in_ready=%0b, want 2 and 0", acc, in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drained   = 0;
        for (int c = 0; c < 10 && drained < 2; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (result !== exps[drained] || tag_out !== tags[drained]) begin
                    errors++;
                    $display("FAIL bp_drain[%0d]: got r=%h t=%h, want r=%h t=%h",
                             drained, result, tag_out, exps[drained], tags[drained]);
                end
                drained++;
            end
            @(posedge clk);
        end
        #1;
        checks++;
        if (drained !== 2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain_count: drained=%0d out_valid=%0b, want 2 and 0", drained, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        operand   = 16'h4000;
        tag_in    = 4'h3;
        @(posedge clk);
        #1;
        operand = 16'h4200;
        tag_in  = 4'h4;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill: out_valid=%0b in_ready=%0b, want 1 and 0", out_valid, in_ready);
        end
        flush   = 1'b1;
        operand = 16'h3E00;
        tag_in  = 4'h5;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: out_valid=%0b want 0", out_valid);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost[%0d]: out_valid=%0b tag=%h, want no result", c, out_valid, tag_out);
            end
        end
        in_valid = 1'b1;
        operand  = 16'h3C00;
        tag_in   = 4'h6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, result, tag_out} !== {1'b1, 16'h3C00, 4'h6}) begin
            errors++;
            $display("FAIL flush_after: got v=%0b r=%h t=%h, want v=1 r=3c00 t=6", out_valid, result, tag_out);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        operand   = 16'h5C00;
        tag_in    = 4'h9;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (out_valid !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: out_valid=%0b ovf=%0b, want 1 and 1", out_valid, ovf);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, result, tag_out, ovf, unf} !== 23'd0) begin
            errors++;
            $display("FAIL areset_outputs: got v=%0b r=%h t=%h o=%0b u=%0b, want all 0",
                     out_valid, result, tag_out, ovf, unf);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_release: out_valid=%0b in_ready=%0b, want 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_exhaustive();
        logic [17:0] exp_v;
        logic [15:0] prev;
        out_ready = 1'b1;
        for (int i = 0; i <= 65536; i++) begin
            if (i < 65536) begin
                in_valid = 1'b1;
                operand  = 16'(i);
                tag_in   = 4'(i);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i >= 1) begin
                prev  = 16'(i - 1);
                exp_v = ref_sq(prev);
                checks++;
                if ({out_valid, tag_out, ovf, unf, result} !== {1'b1, prev[3:0], exp_v}) begin
                    errors++;
                    $display("FAIL sweep op=%h: got v=%0b t=%h o=%0b u=%0b r=%h, want v=1 t=%h o=%0b u=%0b r=%h",
                             prev, out_valid, tag_out, ovf, unf, result,
                             prev[3:0], exp_v[17], exp_v[16], exp_v[15:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
